// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// memory operation codes and default geometry/latency.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int DMEM_ADDR_W      = 10;
  localparam int DMEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM; registered read, no reset on contents.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    rdata_q <= mem[index];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: captures a CPU load/store, stalls for a fixed
// number of wait states, then performs the word access and releases the CPU.
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        misalign_err
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_index;
  logic [31:0]       ram_rdata;
  logic              addr_unused;

  assign addr_unused = ^cpu_addr[31:ADDR_W+2];

  // In IDLE the RAM is pointed at the incoming address so that its registered
  // read is already valid when the zero-wait access step comes one edge later.
  assign ram_index = (state_q == ST_IDLE) ? cpu_addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_read || cpu_write) begin
          stall   = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = WAIT_LD;
          op_d    = cpu_write ? MEM_OP_WRITE : MEM_OP_READ;
          addr_d  = cpu_addr[ADDR_W+1:0];
          wdata_d = cpu_wdata;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (addr_q[1:0] != 2'b00) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (op_q == MEM_OP_WRITE) begin
            ram_we = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MEM_OP_READ;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .index (ram_index),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign cpu_rdata    = rdata_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one instance with 2 wait states, one with 0.
module tb_dmem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;

  logic        rd_a, wr_a, stall_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        rd_b, wr_b, stall_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int total;
  int bad;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] mem_model [2][1024];
  logic [31:0] rdata_model [2];
  int          prev_stall [2];
  int          run_len [2];
  int          done_cnt [2];
  int          wait_of [2];

  dmem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read     (rd_a),
    .cpu_write    (wr_a),
    .cpu_addr     (addr_a),
    .cpu_wdata    (wdata_a),
    .cpu_rdata    (rdata_a),
    .stall        (stall_a),
    .misalign_err (err_a)
  );

  dmem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .cpu_read     (rd_b),
    .cpu_write    (wr_b),
    .cpu_addr     (addr_b),
    .cpu_wdata    (wdata_b),
    .cpu_rdata    (rdata_b),
    .stall        (stall_b),
    .misalign_err (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: word index is byte address / 4 modulo 1024.
  function automatic exp_t modelAccess(input int which, input bit rd, input bit wr,
                                       input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int idx;
    idx = int'((addr / 4) % 1024);
    e.err = 1'b0;
    if (addr % 4 != 0) begin
      rdata_model[which] = 32'd0;
      e.err = 1'b1;
    end else if (wr) begin
      mem_model[which][idx] = data;
    end else if (rd) begin
      rdata_model[which] = mem_model[which][idx];
    end
    e.rdata = rdata_model[which];
    return e;
  endfunction

  task automatic monitorStep(input int which, input logic stl, input logic [31:0] rdat, input logic err);
    exp_t e;
    string tag;
    tag = (which == 0) ? "w2" : "w0";
    if (!reset) begin
      prev_stall[which] = 0;
      run_len[which]    = 0;
    end else begin
      if (stl) begin
        run_len[which]++;
      end else if (prev_stall[which] != 0) begin
        done_cnt[which]++;
        if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
          total++;
          bad++;
          $display("[TB] FAIL %s unexpected_completion: got a completion required none", tag);
        end else begin
          e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
          checkOutput({tag, " rdata"}, rdat, e.rdata);
          checkOutput({tag, " misalign_err"}, {31'd0, err}, {31'd0, e.err});
          checkOutput({tag, " stall_cycles"}, run_len[which], wait_of[which] + 2);
        end
        run_len[which] = 0;
      end
      prev_stall[which] = stl ? 1 : 0;
    end
  endtask

  always @(negedge clk) monitorStep(0, stall_a, rdata_a, err_a);
  always @(negedge clk) monitorStep(1, stall_b, rdata_b, err_b);

  task automatic driveReq(input int which, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data);
    if (which == 0) begin
      rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = data;
    end
  endtask

  // Issues one access at posedge+1, pushes its expectation, waits for completion.
  task automatic applyStimulus(input int which, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data, input bit hold);
    int start;
    bit seen;
    exp_t e;
    start = done_cnt[which];
    e = modelAccess(which, rd, wr, addr, data);
    if (which == 0) q_a.push_back(e); else q_b.push_back(e);
    driveReq(which, rd, wr, addr, data);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt[which] != start) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL completion_timeout: got no completion within 60 cycles required one");
    end
    if (!hold) driveReq(which, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    total = 0;
    bad = 0;
    wait_of[0] = 2;
    wait_of[1] = 0;
    for (int w = 0; w < 2; w++) begin
      prev_stall[w] = 0; run_len[w] = 0; done_cnt[w] = 0; rdata_model[w] = 32'd0;
    end
    reset = 1'b0;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    driveReq(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset stall", {31'd0, stall_a}, 32'd0);
    checkOutput("reset rdata", rdata_a, 32'd0);
    checkOutput("reset misalign_err", {31'd0, err_a}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hCAFE0020, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h22, 32'h1, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'h55, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h8, 32'h1234, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // Abort a write mid-BUSY with reset; the word must keep its old value.
    applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'h11112222, 1'b0);
    driveReq(0, 1'b0, 1'b1, 32'h40, 32'hBAD0BAD0);
    @(posedge clk);
    #1 reset = 1'b0;
    driveReq(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rdata_model[0] = 32'd0;
    rdata_model[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset stall", {31'd0, stall_a}, 32'd0);
    checkOutput("post_reset rdata", rdata_a, 32'd0);
    checkOutput("post_reset misalign_err", {31'd0, err_a}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1'b0, 1'b1, ($urandom() & 32'hFFFF_F000) | (i << 2), $urandom(), 1'b0);
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom() & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2);
      d = $urandom();
      if (kind == 9) a = a | $urandom_range(1, 3);
      applyStimulus(0, (kind <= 4 || kind == 8 || kind == 9), (kind >= 5 && kind <= 8), a, d, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Zero-wait instance: requests held continuously, back to back.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, 1'b1, 32'h100 + (i << 2), $urandom(), 1'b1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1'b1, 1'b0, 32'h100 + ((i % 4) << 2), 32'h0, (i != 5));

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("pending_a", q_a.size(), 32'd0);
    checkOutput("pending_b", q_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the CPU's data-memory port (read/write/address/store-data in, load-data out).
- Holds a word-organised RAM and models a fixed access latency with a wait-state counter.
- Raises a stall toward the CPU until each access completes, and flags misaligned word accesses.

Parameters:
- ADDR_W, 10: word-index width; RAM depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra wait states per access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_read  in  1  load request; held by CPU while stall=1.
- cpu_write  in  1  store request; held by CPU while stall=1.
- cpu_addr  in  32  byte address from ALU result.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid in DONE cycle.
- stall  out  1  CPU must hold pc and request while high.
- misalign_err  out  1  one-cycle pulse: access rejected, addr[1:0] != 0.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, cpu_rdata=0, stall=0, misalign_err=0, captured addr/data/op cleared. RAM contents are not cleared. An access in flight is aborted; no write is committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stall=0, and all registers hold.
  - cpu_read or cpu_write high: stall=1 combinationally in the same cycle. On the clock edge, capture op, addr and wdata, and load the counter with WAIT_CYCLES. Go to BUSY, or straight to the access step if WAIT_CYCLES=0.
  - Both read and write high: treat as a write; the read is ignored.
- BUSY:
  - stall=1 and the counter decrements each cycle.
  - When the counter is 0 on an edge, perform the access and go to DONE.
- Access step:
  - Word index = captured addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
  - If addr[1:0] != 0: no RAM write, cpu_rdata=0, misalign_err=1 in DONE.
  - Write: RAM[index] <= wdata, and cpu_rdata holds its previous value.
  - Read: cpu_rdata <= RAM[index].
- DONE:
  - stall=0 for exactly one cycle, so the CPU advances and consumes cpu_rdata on this edge.
  - misalign_err is high only in this cycle (if set).
  - Next state is IDLE unconditionally. A request still present in the following IDLE cycle is treated as a new access.
- Latency: a request first seen in cycle 0 has stall high in cycles 0..WAIT_CYCLES+1 and DONE in cycle WAIT_CYCLES+2. With WAIT_CYCLES=0, stall is high for cycles 0..1.
- Changes to cpu_addr or cpu_wdata after capture are ignored.
- cpu_rdata is registered and holds its value until the next completed read, misaligned access or reset.
- Read-after-write to the same word returns the newly written data, because accesses are serialised.

Decomposition:
- Shared package riscv_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - MEM_OP_READ / MEM_OP_WRITE constants;
  - the default ADDR_W and WAIT_CYCLES constants.
- One sub-module, dmem_ram: a single-port synchronous 32-bit RAM (we, index, wdata, rdata) with no reset. The controller FSM, counter and capture registers live in dmem_ctrl.

Test Plan:
- Reset then idle: with reset low mid-BUSY, raise reset and keep requests low → stall=0, cpu_rdata=0, misalign_err=0, and the aborted write word is unchanged.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 → stall high for 4 cycles then low for 1. Read 0x10 → cpu_rdata=0xDEADBEEF in the DONE cycle.
- Misaligned: read 0x13 → stall for 4 cycles, then misalign_err=1 for one cycle with cpu_rdata=0. Write 0x22 with 0x1 → word 0x20 is unchanged.
- Wrap-around, ADDR_W=10: write 0x55 to 0x1000, then read 0x0000 → 0x55.
- Simultaneous read+write at 0x8 with data 0x1234 → treated as a write; a later read of 0x8 returns 0x1234.
- WAIT_CYCLES=0 back-to-back reads held continuously → stall pattern 1,1,0,1,1,0, with each DONE cycle returning the correct data.
